// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - CPU bus responder: internal RAM plus timed external req/ack port
module bus_responder #(
  parameter int          RAM_AW   = 11,
  parameter int          TIMEOUT  = 16,
  parameter logic [7:0]  ERR_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic        read_write,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        rdy,
  output logic        ext_req,
  output logic [15:0] ext_addr,
  output logic        ext_we,
  output logic [7:0]  ext_wdata,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata,
  output logic        bus_error
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ext_req_q, ext_req_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic        ext_we_q, ext_we_d;
  logic [7:0]  ext_wdata_q, ext_wdata_d;
  logic        bus_error_q, bus_error_d;

  logic [7:0]        ram [0:(2**RAM_AW)-1];
  logic              is_ext;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;
  logic              unused_addr_bits;

  // The RAM is mirrored over the lower half, so the bits between RAM_AW and 15 are don't-care.
  assign is_ext           = address[15];
  assign ram_idx          = address[RAM_AW-1:0];
  assign unused_addr_bits = ^address[14:RAM_AW];
  assign ram_we           = (state_q == S_IDLE) && !is_ext && read_write;

  always_ff @(posedge clk) begin
    if (rst && ram_we) begin
      ram[ram_idx] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      rdata_q     <= 8'd0;
      ext_req_q   <= 1'b0;
      ext_addr_q  <= 16'd0;
      ext_we_q    <= 1'b0;
      ext_wdata_q <= 8'd0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      ext_req_q   <= ext_req_d;
      ext_addr_q  <= ext_addr_d;
      ext_we_q    <= ext_we_d;
      ext_wdata_q <= ext_wdata_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    ext_addr_d  = ext_addr_q;
    ext_we_d    = ext_we_q;
    ext_wdata_d = ext_wdata_q;
    bus_error_d = bus_error_q;
    case (state_q)
      S_IDLE: begin
        if (is_ext) begin
          ext_addr_d  = address;
          ext_we_d    = read_write;
          ext_wdata_d = data_in;
          cnt_d       = 8'd0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        // Ack wins over a timeout landing in the same cycle.
        if (ext_ack) begin
          if (!ext_we_q) begin
            rdata_d = ext_rdata;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d     = ERR_DATA;
          bus_error_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Registered strobe: follows the next state so it never lingers into DONE.
    ext_req_d = (state_d == S_REQ);
  end

  always_comb begin
    rdy      = 1'b0;
    data_out = ram[ram_idx];
    case (state_q)
      S_IDLE: rdy = !is_ext;
      S_REQ:  rdy = 1'b0;
      S_DONE: begin
        rdy = 1'b1;
        if (!ext_we_q) begin
          data_out = rdata_q;
        end
      end
      default: rdy = 1'b0;
    endcase
  end

  assign ext_req   = ext_req_q;
  assign ext_addr  = ext_addr_q;
  assign ext_we    = ext_we_q;
  assign ext_wdata = ext_wdata_q;
  assign bus_error = bus_error_q;

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-side responder for the CPU bus driven by the control unit and datapath. It answers every CPU bus cycle. Accesses to the lower half of the address space hit an internal RAM with zero wait states. Accesses to the upper half are forwarded to an external memory port over a req/ack handshake, and the CPU is stalled through `rdy` until the port answers or a timeout expires. The block sits between the CPU address/data/read_write outputs and the board-level ROM/IO bus.

## Interface
Parameters:
- `RAM_AW`, 11: internal RAM address width (2^RAM_AW bytes, mirrored across 0x0000–0x7FFF).
- `TIMEOUT`, 16: maximum cycles spent in REQ waiting for `ext_ack`; legal range 2–255.
- `ERR_DATA`, 8'hFF: read data returned on an external timeout.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `address`, in, 16: CPU bus address. Held stable by the CPU while `rdy`=0.
- `read_write`, in, 1: 0 = read, 1 = write (codebase encoding).
- `data_in`, in, 8: CPU write data.
- `data_out`, out, 8: read data to the CPU.
- `rdy`, out, 1: 1 means the current bus cycle completes at the next edge; 0 means the CPU must hold.
- `ext_req`, out, 1: external request strobe.
- `ext_addr`, out, 16: latched external address.
- `ext_we`, out, 1: latched external write enable.
- `ext_wdata`, out, 8: latched external write data.
- `ext_ack`, in, 1: external completion, sampled only in REQ.
- `ext_rdata`, in, 8: external read data, valid with `ext_ack`.
- `bus_error`, out, 1: sticky timeout flag, cleared only by reset.

## Operation
- Decode: `address[15]`=0 selects internal; `address[15]`=1 selects external.
- Internal read: `data_out` = ram[address[RAM_AW-1:0]], asynchronous read. `rdy`=1.
- Internal write: when `read_write`=1, ram[address[RAM_AW-1:0]] <= `data_in` at the edge. `rdy`=1. A same-cycle read returns the old contents.
- External FSM states: IDLE, REQ, DONE.
  - IDLE: if the address is external, `rdy`=0. At the edge, latch `ext_addr`, `ext_we`, `ext_wdata`, clear `cnt`, and go to REQ. Otherwise stay in IDLE.
  - REQ: `ext_req`=1 and `rdy`=0.
    - If `ext_ack`=1: capture `ext_rdata` into `rdata_q` (reads only; writes leave `rdata_q` unchanged) and go to DONE.
    - Else if `cnt`==TIMEOUT-1: set `rdata_q`=ERR_DATA and `bus_error`=1, then go to DONE.
    - Else `cnt`++.
    - Ack has priority over timeout when both occur in the same cycle.
  - DONE: `rdy`=1. For a read, `data_out`=`rdata_q`. At the next edge, go to IDLE unconditionally.
- Back-to-back external accesses to the same address are each treated as a new access. DONE→IDLE never re-launches the finished access without an intervening edge.
- `ext_ack` in IDLE or DONE is ignored.
- External writes never touch the RAM. Internal writes are suppressed while the FSM is not in IDLE.
- No RAM writes occur while `rst`=0. RAM contents are not reset.

## Timing
- Reset values:
  - state = IDLE, `cnt`=0, `rdata_q`=0.
  - `ext_req`=0, `ext_we`=0, `ext_addr`=0, `ext_wdata`=0, `bus_error`=0.
  - `rdy` and `data_out` follow the decode (internal address → `rdy`=1).
- Internal access latency: 0 stall cycles.
- External access, ack in the k-th REQ cycle (k≥1): k+1 stall cycles; `rdy` is high in DONE.
- Timeout: REQ lasts exactly TIMEOUT cycles, then DONE.
- `ext_req` is registered: high exactly for the REQ cycles, with no glitch into DONE.
- Reset mid-transaction: immediate return to IDLE. `ext_req` drops asynchronously and the captured data is discarded.

## Test plan
- Internal write 0x5A to 0x0123, then read 0x0123 → `data_out`=0x5A, `rdy` high throughout. Read 0x0923 (mirror) → 0x5A.
- External read of 0xC000 with `ext_ack` and `ext_rdata`=0x3C on the 3rd REQ cycle → `rdy` low for 4 cycles, then `data_out`=0x3C for one cycle, `bus_error`=0.
- External write 0x77 to 0x8001 with immediate ack → `ext_addr`=0x8001, `ext_we`=1, `ext_wdata`=0x77, `ext_req` high 1 cycle, 2 stall cycles, RAM at 0x0001 unchanged.
- No ack, TIMEOUT=16 → `ext_req` high exactly 16 cycles, `data_out`=0xFF, `bus_error`=1 and still 1 after later good accesses.
- `ext_ack` pulsed while in IDLE on an internal access → no state change. Ack and timeout in the same cycle → `ext_rdata` returned and `bus_error` stays 0.
- Assert `rst` during REQ → `ext_req`=0 and `rdy` follows the decode at once. After release, an internal read works normally.
